// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic stages.
// Holds the sequencer state encoding used by every serial stage so that
// debug tooling and neighbouring blocks decode the state bits the same way.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_full_adder_str.sv
// Structural one-bit full adder built from two half-adder cells and an OR.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out
module full_adder_str (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // half-adder cell 0: a + b
    assign ha0_s = a ^ b;
    assign ha0_c = a & b;

    // half-adder cell 1: partial sum + cin
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;

    // at most one of the two half-adder carries can be set
    assign cout  = ha0_c | ha1_c;

endmodule : full_adder_str

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start and
// consumed one bit pair per clock, LSB first, through a single full-adder
// cell. The result and carry-out are registered on the last shift edge and
// held until the next completion.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request, accepted in IDLE or DONE
//   a, b, cin  : operands and carry-in, captured on accepted start
//   busy       : high while shifting
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : registered result
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic s_n;
    logic c_n;

    full_adder_str u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_q),
        .s    (s_n),
        .cout (c_n)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        c_d      = c_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE behaves like IDLE for a new request, giving
                // back-to-back throughput of one op per WIDTH+1 cycles
                state_d = IDLE;
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    c_d      = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sum_sr_d = {s_n, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                c_d      = c_n;
                if (cnt_q == CNT_LAST) begin
                    // hold the counter on the last bit rather than wrap
                    sum_d   = {s_n, sum_sr_q[WIDTH-1:1]};
                    cout_d  = c_n;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder_ctrl
